// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU: 2-entry skid buffer on a valid/ready
// handshake, architectural NZCV flags, sticky overflow and condition evaluation.
module alu_result_stage #(
   parameter int WIDTH       = 32,
   parameter int ST_NEG      = 3,
   parameter int ST_ZERO     = 2,
   parameter int ST_CARRY    = 1,
   parameter int ST_OVERFLOW = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] result,
   input  logic [3:0]       statusIn,
   input  logic             updateFlags,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] outResult,
   output logic [3:0]       outStatus,
   output logic [3:0]       flags,
   output logic             stickyV,
   input  logic             clrSticky,
   input  logic [3:0]       condCode,
   output logic             condPass
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             in_fire, out_fire;

   logic [WIDTH-1:0] main_result, skid_result;
   logic [3:0]       main_status, skid_status;
   logic             main_upd, skid_upd;

   logic             fl_n, fl_z, fl_c, fl_v;

   assign in_fire  = inValid & inReady;
   assign out_fire = outValid & outReady;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (in_fire) state_nxt = ONE;
         end
         ONE: begin
            if (in_fire && !out_fire)      state_nxt = TWO;
            else if (!in_fire && out_fire) state_nxt = EMPTY;
         end
         TWO: begin
            if (out_fire) state_nxt = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // ---------------- outputs ----------------
   // inReady depends only on registered state, never on outReady.
   always_comb begin
      outValid = 1'b0;
      inReady  = 1'b0;
      case (state)
         EMPTY: begin
            outValid = 1'b0;
            inReady  = 1'b1;
         end
         ONE: begin
            outValid = 1'b1;
            inReady  = 1'b1;
         end
         TWO: begin
            outValid = 1'b1;
            inReady  = 1'b0;
         end
         default: begin
            outValid = 1'b0;
            inReady  = 1'b0;
         end
      endcase
      if (rst) inReady = 1'b0;
   end

   // ---------------- main / skid storage ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         main_result <= '0;
         main_status <= '0;
         main_upd    <= 1'b0;
         skid_result <= '0;
         skid_status <= '0;
         skid_upd    <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_result <= result;
                  main_status <= statusIn;
                  main_upd    <= updateFlags;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_result <= result;
                  main_status <= statusIn;
                  main_upd    <= updateFlags;
               end else if (in_fire) begin
                  skid_result <= result;
                  skid_status <= statusIn;
                  skid_upd    <= updateFlags;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_result <= skid_result;
                  main_status <= skid_status;
                  main_upd    <= skid_upd;
               end
            end
            default: ;
         endcase
      end
   end

   assign outResult = main_result;
   assign outStatus = main_status;

   // ---------------- flags and sticky overflow ----------------
   // A setting consume takes priority over clrSticky in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags   <= '0;
         stickyV <= 1'b0;
      end else begin
         if (out_fire && main_upd) begin
            flags <= main_status;
         end
         if (out_fire && main_upd && main_status[ST_OVERFLOW]) begin
            stickyV <= 1'b1;
         end else if (clrSticky) begin
            stickyV <= 1'b0;
         end
      end
   end

   // ---------------- condition evaluation ----------------
   assign fl_n = flags[ST_NEG];
   assign fl_z = flags[ST_ZERO];
   assign fl_c = flags[ST_CARRY];
   assign fl_v = flags[ST_OVERFLOW];

   always_comb begin
      condPass = 1'b0;
      case (condCode)
         4'd0:  condPass = fl_z;
         4'd1:  condPass = ~fl_z;
         4'd2:  condPass = fl_c;
         4'd3:  condPass = ~fl_c;
         4'd4:  condPass = fl_n;
         4'd5:  condPass = ~fl_n;
         4'd6:  condPass = fl_v;
         4'd7:  condPass = ~fl_v;
         4'd8:  condPass = fl_c & ~fl_z;
         4'd9:  condPass = ~fl_c | fl_z;
         4'd10: condPass = (fl_n == fl_v);
         4'd11: condPass = (fl_n != fl_v);
         4'd12: condPass = ~fl_z & (fl_n == fl_v);
         4'd13: condPass = fl_z | (fl_n != fl_v);
         4'd14: condPass = 1'b1;
         4'd15: condPass = 1'b0;
         default: condPass = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, back-pressure, flags,
// sticky overflow, condition codes and mid-stream reset.
module tb_alu_result_stage;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] result;
   logic [3:0]       statusIn;
   logic             updateFlags;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outResult;
   logic [3:0]       outStatus;
   logic [3:0]       flags;
   logic             stickyV;
   logic             clrSticky;
   logic [3:0]       condCode;
   logic             condPass;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   alu_result_stage #(
      .WIDTH      (WIDTH),
      .ST_NEG     (3),
      .ST_ZERO    (2),
      .ST_CARRY   (1),
      .ST_OVERFLOW(0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inValid    (inValid),
      .inReady    (inReady),
      .result     (result),
      .statusIn   (statusIn),
      .updateFlags(updateFlags),
      .outValid   (outValid),
      .outReady   (outReady),
      .outResult  (outResult),
      .outStatus  (outStatus),
      .flags      (flags),
      .stickyV    (stickyV),
      .clrSticky  (clrSticky),
      .condCode   (condCode),
      .condPass   (condPass)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one beat with outReady high, then let it drain
   task automatic beat(input logic [31:0] r, input logic [3:0] s, input logic u);
      outReady    = 1'b1;
      inValid     = 1'b1;
      result      = r;
      statusIn    = s;
      updateFlags = u;
      tick();
      inValid = 1'b0;
      tick();
   endtask

   task automatic cond(input string tag, input logic [3:0] cc, input logic exp);
      condCode = cc;
      #1;
      chk(tag, condPass, exp);
   endtask

   initial begin
      rst = 1'b1; inValid = 1'b0; result = '0; statusIn = '0; updateFlags = 1'b0;
      outReady = 1'b0; clrSticky = 1'b0; condCode = 4'd14;
      tick();
      tick();
      chk("rst_inReady", inReady, 1'b0);
      chk("rst_outValid", outValid, 1'b0);
      chk("rst_outResult", outResult, 32'h0);
      chk("rst_outStatus", outStatus, 4'h0);
      chk("rst_flags", flags, 4'h0);
      chk("rst_sticky", stickyV, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_rst_inReady", inReady, 1'b1);

      // streaming A then B, outReady held high
      outReady = 1'b1; updateFlags = 1'b1;
      inValid = 1'b1; result = 32'h0000_00F0; statusIn = 4'h0;
      tick();
      chk("A_valid", outValid, 1'b1);
      chk("A_result", outResult, 32'h0000_00F0);
      result = 32'h8000_0000; statusIn = 4'h8;
      tick();
      chk("B_result", outResult, 32'h8000_0000);
      chk("B_status", outStatus, 4'h8);
      chk("flags_after_A", flags, 4'h0);
      inValid = 1'b0;
      tick();
      chk("drain_valid", outValid, 1'b0);
      chk("flags_after_B", flags, 4'h8);
      cond("MI_N", 4'd4, 1'b1);
      cond("PL_N", 4'd5, 1'b0);

      // back-pressure: C1 in main, C2 in skid, C3 stalls
      outReady = 1'b0; updateFlags = 1'b0;
      inValid = 1'b1; result = 32'hC1; statusIn = 4'h0;
      tick();
      result = 32'hC2;
      tick();
      chk("bp_inReady_two", inReady, 1'b0);
      chk("bp_head_C1", outResult, 32'hC1);
      result = 32'hC3;
      tick();
      chk("bp_stable_C1", outResult, 32'hC1);
      chk("bp_still_full", inReady, 1'b0);
      outReady = 1'b1;
      tick();
      chk("bp_C2", outResult, 32'hC2);
      chk("bp_inReady_one", inReady, 1'b1);
      tick();
      chk("bp_C3", outResult, 32'hC3);
      chk("bp_C3_valid", outValid, 1'b1);
      inValid = 1'b0;
      tick();
      chk("bp_empty", outValid, 1'b0);
      chk("bp_flags_kept", flags, 4'h8);

      // zero result
      beat(32'h0, 4'h4, 1'b1);
      chk("zero_flags", flags, 4'h4);
      cond("EQ", 4'd0, 1'b1);
      cond("NE", 4'd1, 1'b0);
      cond("LS_z", 4'd9, 1'b1);
      cond("GT_z", 4'd12, 1'b0);

      // no flag update
      beat(32'h1234, 4'h9, 1'b0);
      chk("noupd_flags", flags, 4'h4);
      chk("noupd_sticky", stickyV, 1'b0);

      // carry only
      beat(32'h5, 4'h2, 1'b1);
      cond("HI_c", 4'd8, 1'b1);
      cond("LS_c", 4'd9, 1'b0);
      cond("CS", 4'd2, 1'b1);
      cond("CC", 4'd3, 1'b0);
      chk("carry_sticky", stickyV, 1'b0);

      // sticky overflow
      beat(32'h7, 4'h1, 1'b1);
      chk("sticky_set", stickyV, 1'b1);
      cond("VS", 4'd6, 1'b1);
      cond("VC", 4'd7, 1'b0);
      cond("GE_v", 4'd10, 1'b0);
      cond("LT_v", 4'd11, 1'b1);
      cond("LE_v", 4'd13, 1'b1);
      cond("AL", 4'd14, 1'b1);
      cond("NV", 4'd15, 1'b0);
      beat(32'h8, 4'h0, 1'b1);
      chk("sticky_hold", stickyV, 1'b1);
      chk("flags_zero", flags, 4'h0);
      inValid = 1'b1; result = 32'h9; statusIn = 4'h1; updateFlags = 1'b1;
      tick();
      inValid = 1'b0; clrSticky = 1'b1;
      tick();
      clrSticky = 1'b0;
      chk("sticky_set_wins", stickyV, 1'b1);
      chk("flags_v", flags, 4'h1);
      clrSticky = 1'b1;
      tick();
      clrSticky = 1'b0;
      chk("sticky_cleared", stickyV, 1'b0);

      // N and V both set
      beat(32'h8000_0001, 4'h9, 1'b1);
      cond("GE_nv", 4'd10, 1'b1);
      cond("GT_nv", 4'd12, 1'b1);

      // reset mid-stream from TWO
      outReady = 1'b0;
      inValid = 1'b1; result = 32'hD1; statusIn = 4'hF; updateFlags = 1'b1;
      tick();
      result = 32'hD2;
      tick();
      chk("mid_two", inReady, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_inReady", inReady, 1'b0);
      tick();
      chk("mid_outValid", outValid, 1'b0);
      chk("mid_flags", flags, 4'h0);
      chk("mid_sticky", stickyV, 1'b0);
      chk("mid_rst_inReady2", inReady, 1'b0);
      rst = 1'b0; inValid = 1'b0; outReady = 1'b1;
      #1;
      chk("mid_after_inReady", inReady, 1'b1);
      tick();
      chk("mid_no_replay", outValid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
